// File: rtl/soc_sysid_uptime_if.sv
// soc_sysid_uptime_if: word-addressed read/write bus between an interconnect master and soc_sysid_uptime
//   address/read/write/writedata : master -> slave request, one-cycle strobes
//   readdata/readdatavalid       : slave -> master response, one cycle after read
interface soc_sysid_uptime_if #(parameter int ADDR_W = 3);
  logic [ADDR_W-1:0] address;
  logic read, write;
  logic [31:0] writedata, readdata;
  logic readdatavalid;
  modport master(output address, read, write, writedata, input readdata, readdatavalid);
  modport slave(input address, read, write, writedata, output readdata, readdatavalid);
endinterface

// File: rtl/soc_sysid_uptime.sv
// soc_sysid_uptime: system ID / build timestamp slave with scratch register and optional 64-bit uptime counter
//   clock, reset_n : single clock, asynchronous active-low reset
//   bus (slave)    : address/read/write/writedata in, readdata/readdatavalid out (read latency 1)
//   Macro SYSID_UPTIME_EN builds uptime, prescaler, hi_shadow, CONTROL and STATUS; otherwise those words read 0.
module soc_sysid_uptime #(
  parameter logic [31:0] ID = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter int ADDR_W = 3,
  parameter int PRESCALE = 1
) (
  input logic clock,
  input logic reset_n,
  soc_sysid_uptime_if.slave bus
);
  if (ADDR_W < 3 || ADDR_W > 8 || PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_cfg
    $error("soc_sysid_uptime: parameter out of range");
  end
  logic rd;
  logic [31:0] scratch, rdata, up_lo, up_hi, ctrl, stat;
  // a write wins over a simultaneous read; the read is dropped
  assign rd = bus.read && !bus.write;
`ifdef SYSID_UPTIME_EN
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [63:0] uptime;
  logic [31:0] hi_shadow;
  logic [PW-1:0] pre;
  logic en, ovf, tick, wrap, clr, wr_ctrl, w1c_ovf;
  assign tick = en && pre == PW'(PRESCALE - 1);
  assign wrap = tick && &uptime;
  assign wr_ctrl = bus.write && bus.address == ADDR_W'(5);
  assign clr = wr_ctrl && bus.writedata[1];
  assign w1c_ovf = bus.write && bus.address == ADDR_W'(6) && bus.writedata[0];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      uptime <= '0;
      pre <= '0;
      hi_shadow <= '0;
      en <= 1'b1;
      ovf <= 1'b0;
    end else begin
      pre <= clr || tick ? '0 : en ? pre + 1'b1 : pre;
      uptime <= clr ? '0 : tick ? uptime + 64'd1 : uptime;
      // LO read latches the pre-increment high word so LO-then-HI is one coherent sample
      hi_shadow <= clr ? '0 : rd && bus.address == ADDR_W'(2) ? uptime[63:32] : hi_shadow;
      en <= wr_ctrl ? bus.writedata[0] : en;
      // a wrap beats a simultaneous write-1-clear
      ovf <= wrap || (ovf && !w1c_ovf);
    end
  assign up_lo = uptime[31:0];
  assign up_hi = hi_shadow;
  assign ctrl = {31'b0, en};
  assign stat = {31'b0, ovf};
`else
  assign up_lo = '0;
  assign up_hi = '0;
  assign ctrl = '0;
  assign stat = '0;
`endif
  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_W'(0): rdata = ID;
      ADDR_W'(1): rdata = TIMESTAMP;
      ADDR_W'(2): rdata = up_lo;
      ADDR_W'(3): rdata = up_hi;
      ADDR_W'(4): rdata = scratch;
      ADDR_W'(5): rdata = ctrl;
      ADDR_W'(6): rdata = stat;
      default: rdata = '0;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      bus.readdata <= '0;
      bus.readdatavalid <= 1'b0;
      scratch <= '0;
    end else begin
      bus.readdatavalid <= rd;
      bus.readdata <= rd ? rdata : bus.readdata;
      scratch <= bus.write && bus.address == ADDR_W'(4) ? bus.writedata : scratch;
    end
endmodule

// File: doc/soc_sysid_uptime.md
# soc_sysid_uptime

Parametrised system-ID slave for the SoC interconnect, successor to the fixed two-word ID block. It returns a configurable ID and build timestamp, and adds a 64-bit free-running uptime counter with atomic two-word readout, a scratch register and counter control/status. Software uses it to check the hardware build and to read elapsed time. Registered read path with fixed latency of 1.

## Interface
- `ID`, 32'h0000_0000: system ID value returned at word 0.
- `TIMESTAMP`, 32'h0000_0000: build timestamp returned at word 1.
- `ADDR_W`, 3: word-address width; legal range 3..8.
- `PRESCALE`, 1: clocks per uptime increment; legal range 1..65535.
- `clock`  in  1  single clock; all state is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  ADDR_W  word address.
- `read`  in  1  read strobe, one cycle per access.
- `write`  in  1  write strobe, one cycle per access.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data; reset 0.
- `readdatavalid`  out  1  high for exactly one cycle when `readdata` is valid; reset 0.

## Operation
- Word 0 ID (RO). Returns `ID`.
- Word 1 TIMESTAMP (RO). Returns `TIMESTAMP`.
- Word 2 UPTIME_LO (RO). Returns uptime[31:0]. The same read copies uptime[63:32] into the 32-bit shadow register `hi_shadow`.
- Word 3 UPTIME_HI (RO). Returns `hi_shadow`, not the live counter. Reading LO then HI gives one coherent 64-bit sample.
- Word 4 SCRATCH (RW). Reset value 0.
- Word 5 CONTROL.
  - bit0 EN: reset value 1. When 0, the counter and prescaler hold.
  - bit1 CLR: write 1 to zero the uptime counter, prescaler and `hi_shadow`. Self-clearing; always reads 0.
- Word 6 STATUS.
  - bit0 OVF: sticky; set when the 64-bit uptime wraps.
  - Write 1 to clear.
- Unused bits read 0. Other addresses read 0 and ignore writes.
- Prescaler: counts 0..PRESCALE-1 while EN=1. A tick occurs on the cycle it sits at PRESCALE-1; it then returns to 0 and uptime increments by 1. With PRESCALE=1, every EN cycle is a tick.
- Uptime wraps from all-ones to 0 on a tick, setting OVF.
- Register state after reset: uptime 0, prescaler 0, `hi_shadow` 0, SCRATCH 0, EN 1, OVF 0.

## Timing
- Read latency: 1 clock. A `read` in cycle N gives `readdata`/`readdatavalid` in cycle N+1.
- Back-to-back reads are allowed on every cycle.
- `readdata` holds its last value when `readdatavalid`=0.
- Writes take effect on the edge that samples `write`.
- `read` and `write` asserted together: the write is performed and the read is dropped (no `readdatavalid`).
- UPTIME_LO read on a tick cycle: returns the pre-increment low word, and `hi_shadow` takes the pre-increment high word. The sample stays consistent.
- CLR priority: CLR on the same edge as a tick wins; uptime becomes 0, not 1.
- OVF priority: a wrap on the same edge as an OVF write-1-clear wins; OVF stays 1.
- A CONTROL write with EN=0 stops counting from the next edge. A tick due on that same edge still occurs.
- Reset asserted mid-operation: all state returns asynchronously to its reset value. An in-flight read is lost and `readdatavalid` is 0 on the next cycle.

## Configuration
- Macro `SYSID_UPTIME_EN`.
- Defined: uptime counter, prescaler, `hi_shadow`, CONTROL and STATUS are built as described above.
- Undefined:
  - None of that logic is built.
  - Words 2, 3, 5 and 6 read 0 and ignore writes.
  - ID, TIMESTAMP and SCRATCH behave the same; read latency is still 1.

## Test plan
- Reset, then read words 0, 1 and 7 with ID=32'h6601_0194, TIMESTAMP=32'h5C3A_9F00 -> 32'h6601_0194, 32'h5C3A_9F00 and 0, each with `readdatavalid` exactly 1 cycle after `read`.
- Write SCRATCH=32'hDEAD_BEEF with `read` also high, then read SCRATCH -> no `readdatavalid` on the write cycle; the read returns 32'hDEAD_BEEF.
- PRESCALE=4, run 40 cycles after reset, read UPTIME_LO -> 10 (±1 by read alignment). Then write CLR in the same cycle as a tick -> next LO read counts from 0.
- Force uptime to 64'h0000_0000_FFFF_FFFF, read LO on the tick cycle, then HI after 5 ticks -> LO=32'hFFFF_FFFF, HI=0 (from the shadow, not the live value 1).
- Force uptime to all-ones, tick and write OVF=1 on the same edge -> wraps to 0, STATUS reads 1. A later write 1 to OVF -> STATUS reads 0.
- Build without `SYSID_UPTIME_EN`: read words 2, 3, 5 and 6 after 100 cycles -> all 0. Assert `reset_n` mid-read -> `readdatavalid` 0 and `readdata` 0.
